// File: rtl/avlon_arb_pkg.sv
// Shared definitions for the two-requester Avalon-MM burst arbiter.
package avlon_arb_pkg;

    localparam int unsigned DATA_W_DEF  = 128;
    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned BURST_W_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_BURST = 2'd1,
        ST_RD_ADDR  = 2'd2,
        ST_RD_DATA  = 2'd3
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/avlon_rr_arb2.sv
// Two-requester round-robin winner selection; the priority pointer moves when a burst is released.
module avlon_rr_arb2
    import avlon_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_update,
    input  logic       i_last_m0,
    output logic [1:0] o_winner_c
);

    logic r_prio_m1;

    // The requester not served most recently gets priority next time.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prio_m1 <= 1'b0;
        end else if (i_update) begin
            r_prio_m1 <= i_last_m0;
        end
    end

    always_comb begin
        o_winner_c = GNT_NONE;
        case (i_req)
            2'b01:   o_winner_c = GNT_M0;
            2'b10:   o_winner_c = GNT_M1;
            2'b11:   o_winner_c = r_prio_m1 ? GNT_M1 : GNT_M0;
            default: o_winner_c = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/avlon_mm_arbiter.sv
// Two-master to one burst-slave Avalon-MM arbiter: grant FSM, beat counter and
// combinational command/response muxing.
module avlon_mm_arbiter
    import avlon_arb_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned BURST_W = BURST_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  m0_address,
    input  logic [BURST_W-1:0] m0_burstcount,
    input  logic               m0_read,
    input  logic               m0_write,
    input  logic [DATA_W-1:0]  m0_writedata,
    output logic               m0_waitrequest,
    output logic [DATA_W-1:0]  m0_readdata,
    output logic               m0_readdatavalid,
    input  logic [ADDR_W-1:0]  m1_address,
    input  logic [BURST_W-1:0] m1_burstcount,
    input  logic               m1_read,
    input  logic               m1_write,
    input  logic [DATA_W-1:0]  m1_writedata,
    output logic               m1_waitrequest,
    output logic [DATA_W-1:0]  m1_readdata,
    output logic               m1_readdatavalid,
    output logic [ADDR_W-1:0]  avs_address,
    output logic [BURST_W-1:0] avs_burstcount,
    output logic               avs_read,
    output logic               avs_write,
    output logic [DATA_W-1:0]  avs_writedata,
    output logic               avs_beginbursttransfer,
    input  logic               avs_waitrequest,
    input  logic [DATA_W-1:0]  avs_readdata,
    input  logic               avs_readdatavalid,
    output logic [1:0]         grant,
    output logic               busy
);

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    logic [1:0]         r_grant;
    logic [1:0]         w_grant_nxt;
    logic [BURST_W-1:0] r_cnt;
    logic [BURST_W-1:0] w_cnt_nxt;
    logic               r_bbt;
    logic               w_bbt_nxt;
    logic               w_release;
    logic [1:0]         w_req;
    logic [1:0]         w_winner;
    logic               w_win_write;
    logic [BURST_W-1:0] w_win_bc;
    logic [ADDR_W-1:0]  w_g_addr;
    logic [BURST_W-1:0] w_g_bc;
    logic [DATA_W-1:0]  w_g_wdata;
    logic               w_g_read;
    logic               w_g_write;
    logic               w_cmd_phase;
    logic               w_wr_beat;
    logic               w_rd_accept;

    assign w_req = {m1_read | m1_write, m0_read | m0_write};

    avlon_rr_arb2 u_rr (
        .clk        (clk),
        .reset      (reset),
        .i_req      (w_req),
        .i_update   (w_release),
        .i_last_m0  (r_grant[0]),
        .o_winner_c (w_winner)
    );

    assign w_win_write = w_winner[1] ? m1_write      : m0_write;
    assign w_win_bc    = w_winner[1] ? m1_burstcount : m0_burstcount;

    // Command mux follows the registered owner.
    assign w_g_addr  = r_grant[1] ? m1_address    : m0_address;
    assign w_g_bc    = r_grant[1] ? m1_burstcount : m0_burstcount;
    assign w_g_wdata = r_grant[1] ? m1_writedata  : m0_writedata;
    assign w_g_read  = r_grant[1] ? m1_read       : m0_read;
    assign w_g_write = r_grant[1] ? m1_write      : m0_write;

    assign w_cmd_phase = (r_state == ST_WR_BURST) || (r_state == ST_RD_ADDR);
    assign w_wr_beat   = avs_write && !avs_waitrequest;
    assign w_rd_accept = avs_read && !avs_waitrequest;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_grant <= GNT_NONE;
            r_cnt   <= '0;
            r_bbt   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bbt   <= w_bbt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_cnt_nxt   = r_cnt;
        w_bbt_nxt   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_grant_nxt = w_winner;
                    w_cnt_nxt   = (w_win_bc == '0) ? BURST_W'(1) : w_win_bc;
                    w_bbt_nxt   = 1'b1;
                    w_state_nxt = w_win_write ? ST_WR_BURST : ST_RD_ADDR;
                end
            end
            ST_WR_BURST: begin
                if (w_wr_beat) begin
                    if (r_cnt != '0) w_cnt_nxt = r_cnt - BURST_W'(1);
                    if (r_cnt <= BURST_W'(1)) w_release = 1'b1;
                end
            end
            ST_RD_ADDR: begin
                if (w_rd_accept) w_state_nxt = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                // Only beats in this state count; stray valids elsewhere are ignored.
                if (avs_readdatavalid) begin
                    if (r_cnt != '0) w_cnt_nxt = r_cnt - BURST_W'(1);
                    if (r_cnt <= BURST_W'(1)) w_release = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_release) begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = GNT_NONE;
        end
    end

    assign avs_address            = w_g_addr;
    assign avs_burstcount         = w_g_bc;
    assign avs_writedata          = w_g_wdata;
    assign avs_write              = (r_state == ST_WR_BURST) && w_g_write;
    assign avs_read               = (r_state == ST_RD_ADDR) && w_g_read;
    assign avs_beginbursttransfer = r_bbt;

    assign m0_waitrequest = (r_grant[0] && w_cmd_phase) ? avs_waitrequest : 1'b1;
    assign m1_waitrequest = (r_grant[1] && w_cmd_phase) ? avs_waitrequest : 1'b1;

    assign m0_readdata      = avs_readdata;
    assign m1_readdata      = avs_readdata;
    assign m0_readdatavalid = avs_readdatavalid && r_grant[0];
    assign m1_readdatavalid = avs_readdatavalid && r_grant[1];

    assign grant = r_grant;
    assign busy  = (r_state != ST_IDLE);

endmodule
